// File: rtl/jk_counter_ctrl.sv
// Controller driving a bank of WIDTH JK flip-flops as a loadable up/down counter
// with limit detection, wrap/reload, pause (HOLD) and a one-cycle completion pulse.
module jk_counter_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             up_dn,
  input  logic             wrap,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  // Handshake: start is a level request sampled in IDLE/HOLD, stop a level
  // request sampled in RUN; neither is acknowledged, the state change is the reply.
  typedef enum logic [2:0] {IDLE, LOAD, RUN, HOLD, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] tgl;
  logic [WIDTH-1:0] q_nx;
  logic             carry;
  logic             reload;

  // Synchronous-counter toggle enables: bit i toggles when all lower bits are
  // 1 (up) or all 0 (down).
  always_comb begin
    tgl   = '0;
    carry = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      tgl[i] = carry;
      carry  = carry & (up_dn ? q[i] : ~q[i]);
    end
  end

  always_comb begin
    state_nx = state;
    j        = '0;
    k        = '0;
    reload   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = load ? LOAD : RUN;
      end
      LOAD: begin
        j        = load_val;
        k        = ~load_val;
        state_nx = RUN;
      end
      RUN: begin
        if (stop) begin
          state_nx = HOLD;
        end else if (en) begin
          if (q == limit) begin
            if (wrap) begin
              j      = load_val;
              k      = ~load_val;
              reload = 1'b1;
            end else begin
              state_nx = DONE;
            end
          end else begin
            j = tgl;
            k = tgl;
          end
        end
      end
      HOLD: begin
        if (start && !stop) state_nx = RUN;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // The JK cells themselves.
  always_comb begin
    q_nx = q;
    for (int i = 0; i < WIDTH; i++) begin
      case ({j[i], k[i]})
        2'b01:   q_nx[i] = 1'b0;
        2'b10:   q_nx[i] = 1'b1;
        2'b11:   q_nx[i] = ~q[i];
        default: q_nx[i] = q[i];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      q     <= '0;
      done  <= 1'b0;
      tc    <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      q     <= q_nx;
      done  <= (state_nx == DONE);
      tc    <= reload;
      busy  <= (state_nx == LOAD) || (state_nx == RUN) || (state_nx == HOLD);
    end
  end

endmodule

// File: tb/tb_jk_counter_ctrl.sv
// Directed bench for jk_counter_ctrl (WIDTH=4): count, preload, wrap, hold,
// async reset and load==limit sequences with hand-computed expectations.
module tb_jk_counter_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, stop, en, up_dn, wrap, load;
  logic [W-1:0] load_val, limit;
  logic [W-1:0] j, k, q;
  logic         busy, done, tc;

  int total = 0;
  int bad   = 0;

  jk_counter_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .en(en),
    .up_dn(up_dn), .wrap(wrap), .load(load), .load_val(load_val),
    .limit(limit), .j(j), .k(k), .q(q), .busy(busy), .done(done), .tc(tc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] seq22 [5];
    logic [W-1:0] seq23 [6];
    seq22 = '{4'd2, 4'd1, 4'd0, 4'd15, 4'd14};
    seq23 = '{4'd3, 4'd4, 4'd2, 4'd3, 4'd4, 4'd2};

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; en = 1'b0; up_dn = 1'b1;
    wrap = 1'b0; load = 1'b0; load_val = '0; limit = '0;
    #2;
    chk("rst_q", q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tc", tc, 0);
    chk("rst_j", j, 0);
    chk("rst_k", k, 0);
    #10 rst_n = 1'b1;
    step();

    // Plain up-count 0..5 then finish
    start = 1'b1; load = 1'b0; up_dn = 1'b1; en = 1'b1; wrap = 1'b0; limit = 4'd5;
    #1 chk("idle_j", j, 0);
    step();
    chk("run_busy", busy, 1);
    chk("run_q0", q, 0);
    start = 1'b0;
    #1 chk("up_j0", j, 4'b0001);
    chk("up_k0", k, 4'b0001);
    for (int v = 1; v <= 5; v++) begin
      step();
      chk("up_q", q, v);
      if (v == 3) chk("up_j3", j, 4'b0111);
    end
    chk("lim_j", j, 0);
    chk("lim_done_early", done, 0);
    step();
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_q", q, 5);
    step();
    chk("done_clr", done, 0);
    chk("idle_q", q, 5);
    chk("idle_busy", busy, 0);

    // Preloaded down-count through zero
    start = 1'b1; load = 1'b1; load_val = 4'd3; up_dn = 1'b0; limit = 4'd14;
    step();
    chk("load_busy", busy, 1);
    chk("load_qold", q, 5);
    start = 1'b0; load = 1'b0;
    #1 chk("load_j", j, 4'b0011);
    chk("load_k", k, 4'b1100);
    step();
    chk("dn_q3", q, 3);
    chk("dn_j3", j, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("dn_q", q, seq22[i]);
      if (seq22[i] == 0) chk("dn_j0", j, 4'b1111);
    end
    step();
    chk("dn_done", done, 1);
    chk("dn_done_q", q, 14);
    step();
    chk("dn_done_clr", done, 0);

    // Wrap mode reload with tc
    start = 1'b1; load = 1'b1; load_val = 4'd2; limit = 4'd4; wrap = 1'b1; up_dn = 1'b1;
    step();
    start = 1'b0; load = 1'b0;
    step();
    chk("wr_q2", q, 2);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("wr_q", q, seq23[i]);
      chk("wr_tc", tc, (seq23[i] == 2) ? 1 : 0);
      chk("wr_done", done, 0);
      if (seq23[i] == 4) begin
        chk("wr_rl_j", j, 4'b0010);
        chk("wr_rl_k", k, 4'b1101);
      end
    end

    // Pause at 7 with stop+en, resume at 8
    wrap = 1'b0; limit = 4'd15;
    for (int v = 3; v <= 7; v++) begin
      step();
      chk("pre_hold_q", q, v);
    end
    stop = 1'b1;
    #1 chk("stop_j", j, 0);
    step();
    chk("hold_q", q, 7);
    chk("hold_busy", busy, 1);
    stop = 1'b0; en = 1'b0;
    step();
    chk("hold_q_en0", q, 7);
    en = 1'b1;
    step();
    chk("hold_q_en1", q, 7);
    start = 1'b1; load = 1'b1; load_val = 4'd0;
    step();
    chk("resume_q", q, 7);
    start = 1'b0; load = 1'b0;
    step();
    chk("resume_q8", q, 8);
    en = 1'b0;
    step();
    chk("en0_q", q, 8);
    en = 1'b1;
    step();
    chk("run_q9", q, 9);

    // Asynchronous reset mid-RUN
    #2 rst_n = 1'b0;
    #1 chk("arst_q", q, 0);
    chk("arst_busy", busy, 0);
    chk("arst_j", j, 0);
    chk("arst_k", k, 0);
    step();
    #2 rst_n = 1'b1;
    step();
    chk("post_rst_q", q, 0);
    chk("post_rst_busy", busy, 0);
    step();
    chk("post_rst_q2", q, 0);

    // load_val == limit: LOAD, one RUN cycle, done
    start = 1'b1; load = 1'b1; load_val = 4'd6; limit = 4'd6; wrap = 1'b0; up_dn = 1'b1;
    #1 chk("eq_idle_j", j, 0);
    step();
    chk("eq_load_busy", busy, 1);
    start = 1'b0; load = 1'b0;
    #1 chk("eq_load_j", j, 4'b0110);
    chk("eq_load_k", k, 4'b1001);
    step();
    chk("eq_run_q", q, 6);
    chk("eq_run_j", j, 0);
    chk("eq_run_k", k, 0);
    chk("eq_run_done", done, 0);
    step();
    chk("eq_done", done, 1);
    chk("eq_done_q", q, 6);
    step();
    chk("eq_done_clr", done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
